// File: rtl/sysex_tx_framer_if.sv
// sysex_tx_framer_if: byte handshake from the SysEx framer to the MIDI UART transmitter
//   tx_data  : byte offered to the UART
//   tx_valid : tx_data is valid; a byte moves on an edge with tx_valid && tx_ready
//   tx_ready : UART accepts the offered byte
interface sysex_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/sysex_tx_framer.sv
// sysex_tx_framer: builds Educational-Use SysEx frames (patch dump / single parameter) for the MIDI UART
//   reg_clk, reset_reg_N : clock, synchronous active-low reset
//   midi_ch_i            : channel nibble, latched when a request is accepted
//   dump_req_i           : start a patch dump (wins over param_req_i)
//   param_req_i          : start a parameter frame using param_bank_i/param_addr_i/param_data_i
//   syx_bank_addr_o/syx_dec_addr_o, synth_data_out_i : register-file read port, one-cycle latency
//   tx                   : byte stream to the UART
//   busy_o, done_o, data_ovr_o : frame in progress, end-of-frame pulse, sticky payload bit-7 flag
module sysex_tx_framer #(
    parameter logic [7:0] MFR_ID        = 8'h7D,
    parameter int         BANK_LEN      = 64,
    parameter int         LAST_BANK_LEN = 32
) (
    input  logic                     reg_clk,
    input  logic                     reset_reg_N,
    input  logic [3:0]               midi_ch_i,
    input  logic                     dump_req_i,
    input  logic                     param_req_i,
    input  logic [2:0]               param_bank_i,
    input  logic [6:0]               param_addr_i,
    input  logic [7:0]               param_data_i,
    output logic [2:0]               syx_bank_addr_o,
    output logic [6:0]               syx_dec_addr_o,
    input  logic [7:0]               synth_data_out_i,
    sysex_tx_framer_if.master        tx,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     data_ovr_o
);
    typedef enum logic [3:0] {
        IDLE, SOX, ID, CMD, P_BANK, P_ADDR, P_DATA, RD_ADDR, RD_WAIT, DATA, EOX
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic [2:0] bank_q, bank_d;
    logic [6:0] addr_q, addr_d;
    logic       is_dump_q, is_dump_d;
    logic [3:0] ch_q, ch_d;
    logic [2:0] p_bank_q, p_bank_d;
    logic [6:0] p_addr_q, p_addr_d;
    logic [7:0] p_data_q, p_data_d;
    logic       xfer;
    logic [6:0] addr_last;

    assign xfer      = tx_valid_q && tx.tx_ready;
    assign addr_last = (bank_q == 3'd5) ? 7'(LAST_BANK_LEN - 1) : 7'(BANK_LEN - 1);

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        is_dump_d  = is_dump_q;
        ch_d       = ch_q;
        p_bank_d   = p_bank_q;
        p_addr_d   = p_addr_q;
        p_data_d   = p_data_q;
        case (state_q)
            IDLE: if (dump_req_i || param_req_i) begin
                state_d    = SOX;
                is_dump_d  = dump_req_i;
                ch_d       = midi_ch_i;
                p_bank_d   = param_bank_i;
                p_addr_d   = param_addr_i;
                p_data_d   = param_data_i;
                busy_d     = 1'b1;
                ovr_d      = 1'b0;
                tx_data_d  = 8'hF0;
                tx_valid_d = 1'b1;
            end
            SOX: if (xfer) begin
                state_d   = ID;
                tx_data_d = MFR_ID;
            end
            ID: if (xfer) begin
                state_d   = CMD;
                tx_data_d = {is_dump_q ? 4'h7 : 4'h1, ch_q};
            end
            CMD: if (xfer) begin
                if (is_dump_q) begin
                    state_d    = RD_ADDR;
                    tx_valid_d = 1'b0;
                    bank_d     = 3'd0;
                    addr_d     = 7'd0;
                end else begin
                    state_d   = P_BANK;
                    tx_data_d = {5'b0, p_bank_q};
                end
            end
            P_BANK: if (xfer) begin
                state_d   = P_ADDR;
                tx_data_d = {1'b0, p_addr_q};
            end
            P_ADDR: if (xfer) begin
                state_d   = P_DATA;
                tx_data_d = {1'b0, p_data_q[6:0]};
                ovr_d     = ovr_q | p_data_q[7];
            end
            P_DATA: if (xfer) begin
                state_d   = EOX;
                tx_data_d = 8'hF7;
            end
            RD_ADDR: state_d = RD_WAIT;
            // read data for the address driven in RD_ADDR is present during this cycle
            RD_WAIT: begin
                state_d    = DATA;
                tx_data_d  = {1'b0, synth_data_out_i[6:0]};
                tx_valid_d = 1'b1;
                ovr_d      = ovr_q | synth_data_out_i[7];
            end
            DATA: if (xfer) begin
                if (addr_q == addr_last && bank_q == 3'd5) begin
                    state_d   = EOX;
                    tx_data_d = 8'hF7;
                end else begin
                    state_d    = RD_ADDR;
                    tx_valid_d = 1'b0;
                    // banks run 0,1,2 then jump to 5
                    bank_d     = (addr_q != addr_last) ? bank_q : (bank_q == 3'd2) ? 3'd5 : bank_q + 3'd1;
                    addr_d     = (addr_q == addr_last) ? 7'd0 : addr_q + 7'd1;
                end
            end
            EOX: if (xfer) begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_N) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            bank_q     <= 3'd0;
            addr_q     <= 7'd0;
            is_dump_q  <= 1'b0;
            ch_q       <= 4'd0;
            p_bank_q   <= 3'd0;
            p_addr_q   <= 7'd0;
            p_data_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            is_dump_q  <= is_dump_d;
            ch_q       <= ch_d;
            p_bank_q   <= p_bank_d;
            p_addr_q   <= p_addr_d;
            p_data_q   <= p_data_d;
        end
    end

    assign tx.tx_data      = tx_data_q;
    assign tx.tx_valid     = tx_valid_q;
    assign syx_bank_addr_o = bank_q;
    assign syx_dec_addr_o  = addr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign data_ovr_o      = ovr_q;
endmodule

// File: tb/tb_sysex_tx_framer.sv
// tb_sysex_tx_framer: scoreboard bench for sysex_tx_framer
module tb_sysex_tx_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] midi_ch = 4'd0;
    logic       dump_req = 1'b0;
    logic       param_req = 1'b0;
    logic [2:0] param_bank = 3'd0;
    logic [6:0] param_addr = 7'd0;
    logic [7:0] param_data = 8'd0;
    logic [2:0] rf_bank;
    logic [6:0] rf_addr;
    logic [7:0] rf_data;
    logic       busy, done, data_ovr;
    logic [7:0] mem [0:7][0:127];
    logic [7:0] exp_q [$];
    logic [7:0] prev_data = 8'd0;
    bit         stall_prev = 1'b0;
    bit         rnd_ready = 1'b0;
    int         n_cmp = 0, n_fail = 0, n_rx = 0, n_done = 0, n_busy = 0;

    sysex_tx_framer_if tx ();

    sysex_tx_framer dut (
        .reg_clk          (clk),
        .reset_reg_N      (rst_n),
        .midi_ch_i        (midi_ch),
        .dump_req_i       (dump_req),
        .param_req_i      (param_req),
        .param_bank_i     (param_bank),
        .param_addr_i     (param_addr),
        .param_data_i     (param_data),
        .syx_bank_addr_o  (rf_bank),
        .syx_dec_addr_o   (rf_addr),
        .synth_data_out_i (rf_data),
        .tx               (tx),
        .busy_o           (busy),
        .done_o           (done),
        .data_ovr_o       (data_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rf_data <= mem[rf_bank][rf_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_step();
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {23'd0, tx.tx_valid, tx.tx_data}, {23'd0, 1'b1, prev_data});
            if (tx.tx_valid && tx.tx_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte", tx.tx_data);
                end else begin
                    chk("tx_byte", 32'(tx.tx_data), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = tx.tx_valid && !tx.tx_ready;
            prev_data  = tx.tx_data;
            if (done) n_done++;
            if (busy) n_busy++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input logic [3:0] ch);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back({4'h7, ch});
        for (int b = 0; b < 4; b++) begin
            int bk = (b == 3) ? 5 : b;
            for (int a = 0; a < ((bk == 5) ? 32 : 64); a++)
                exp_q.push_back({1'b0, mem[bk][a][6:0]});
        end
        exp_q.push_back(8'hF7);
    endtask

    task automatic push_param(input logic [3:0] ch, input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back({4'h1, ch});
        exp_q.push_back({5'd0, b});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, d[6:0]});
        exp_q.push_back(8'hF7);
    endtask

    task automatic pulse(input bit d, input bit p);
        n_rx   = 0;
        n_busy = 0;
        dump_req  = d;
        param_req = p;
        tick();
        dump_req  = 1'b0;
        param_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int start = n_done;
        int t = 0;
        while (n_done == start && t < limit) begin
            tick();
            t++;
        end
        if (n_done == start) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, limit);
        end
        tick();
    endtask

    task automatic wait_rx(input int n, input int limit);
        int t = 0;
        while (n_rx < n && t < limit) begin
            tick();
            t++;
        end
        if (n_rx < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_timeout: got %0d bytes expected %0d", n_rx, n);
        end
    endtask

    task automatic check_reset();
        chk("rst_tx_valid", 32'(tx.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx.tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data_ovr", 32'(data_ovr), 32'd0);
        chk("rst_bank", 32'(rf_bank), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
    endtask

    task automatic check_dump_end(input string name, input int d0);
        chk({name, "_bytes"}, 32'(n_rx), 32'd228);
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 128; a++)
                mem[b][a] = 8'((b * 16 + a) & 'h7F);
        tx.tx_ready = 1'b0;
        fork
            forever begin
                @(posedge clk);
                #1;
                tx.tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
            end
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) tick();
        check_reset();
        rst_n = 1'b1;
        tick();

        // parameter frame; inputs change after acceptance to prove latching
        midi_ch = 4'd3; param_bank = 3'd2; param_addr = 7'h15; param_data = 8'h40;
        push_param(4'd3, 3'd2, 7'h15, 8'h40);
        d0 = n_done;
        pulse(1'b0, 1'b1);
        midi_ch = 4'd9; param_bank = 3'd7; param_addr = 7'h7F; param_data = 8'hFF;
        chk("param_busy_start", 32'(busy), 32'd1);
        wait_done("param", 100);
        chk("param_bytes", 32'(n_rx), 32'd7);
        chk("param_busy_cycles", 32'(n_busy), 32'd7);
        chk("param_done_cnt", 32'(n_done - d0), 32'd1);
        chk("param_left", 32'(exp_q.size()), 32'd0);
        chk("param_busy_end", 32'(busy), 32'd0);

        // full dump, ready tied high: 676 busy cycles
        midi_ch = 4'd0;
        push_dump(4'd0);
        d0 = n_done;
        pulse(1'b1, 1'b0);
        wait_done("dump", 2000);
        check_dump_end("dump", d0);
        chk("dump_busy_cycles", 32'(n_busy), 32'd676);
        chk("dump_ovr", 32'(data_ovr), 32'd0);
        chk("idle_addr_hold", {25'd0, rf_addr}, 32'd31);

        // backpressure
        rnd_ready = 1'b1;
        push_dump(4'd0);
        d0 = n_done;
        pulse(1'b1, 1'b0);
        wait_done("bp", 8000);
        check_dump_end("bp", d0);
        rnd_ready = 1'b0;
        tick();

        // overrange byte in bank 1 addr 5 goes out as 0x43
        mem[1][5] = 8'hC3;
        push_dump(4'd0);
        chk("ovr_expected_43", 32'(exp_q[3 + 64 + 5]), 32'h43);
        d0 = n_done;
        pulse(1'b1, 1'b0);
        wait_done("ovr", 2000);
        check_dump_end("ovr", d0);
        chk("ovr_sticky", 32'(data_ovr), 32'd1);
        mem[1][5] = 8'h15;
        midi_ch = 4'd1; param_bank = 3'd0; param_addr = 7'h00; param_data = 8'h11;
        push_param(4'd1, 3'd0, 7'h00, 8'h11);
        pulse(1'b0, 1'b1);
        chk("ovr_cleared", 32'(data_ovr), 32'd0);
        wait_done("ovr_param", 100);
        chk("ovr_param_left", 32'(exp_q.size()), 32'd0);

        // simultaneous requests, then param_req mid-dump
        midi_ch = 4'd2; param_bank = 3'd3; param_addr = 7'h22; param_data = 8'h33;
        push_dump(4'd2);
        d0 = n_done;
        pulse(1'b1, 1'b1);
        wait_rx(50, 1000);
        param_req = 1'b1;
        tick();
        param_req = 1'b0;
        wait_done("arb", 2000);
        repeat (20) tick();
        check_dump_end("arb", d0);

        // reset in the middle of payload byte 100
        midi_ch = 4'd0;
        push_dump(4'd0);
        pulse(1'b1, 1'b0);
        wait_rx(103, 1000);
        rst_n = 1'b0;
        tick();
        check_reset();
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_no_tx", 32'(tx.tx_valid), 32'd0);
        push_dump(4'd0);
        d0 = n_done;
        pulse(1'b1, 1'b0);
        wait_done("post_rst", 2000);
        check_dump_end("post_rst", d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
